// File: rtl/qenc_pkg.sv
// Shared types and defaults for the quadrature encoder / pushbutton controller.
package qenc_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int DEB_CYCLES_DEF  = 16;
  localparam int PB_CNT_W_DEF    = 12;
  localparam int LONG_CYCLES_DEF = 2000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'd0,
    DELTA_CW   = 2'd1,
    DELTA_CCW  = 2'd2,
    DELTA_ERR  = 2'd3
  } phase_delta_t;

  // Position of {A,B} along the CW Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  function automatic phase_delta_t phase_delta(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] p;
    logic [1:0] c;
    p = gray_pos(prev);
    c = gray_pos(cur);
    if ((prev ^ cur) == 2'b11)  return DELTA_ERR;
    else if (c == p + 2'd1)     return DELTA_CW;
    else if (c == p - 2'd1)     return DELTA_CCW;
    else                        return DELTA_NONE;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stability debouncer; the output level
// moves only after DEB_CYCLES consecutive differing synchronized samples.
module input_debounce
  import qenc_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic RST_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int            TW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TC_LOAD = TW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= RST_LEVEL;
      sync_q2 <= RST_LEVEL;
      dout    <= RST_LEVEL;
      timer   <= TC_LOAD;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      if (sync_q2 == dout) begin
        timer <= TC_LOAD;
      end else if (timer == '0) begin
        dout  <= sync_q2;
        timer <= TC_LOAD;
      end else begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder_ctrl.sv
// Rotary encoder decoder with position counter plus pushbutton press classifier.
// Define QENC_LONG_PRESS_EN to build the long-press state and pb_long output.
//
// button state | meaning
// IDLE         | released; pb_cnt holds the length of the last press
// PRESSED      | held, shorter than LONG_CYCLES so far
// LONG         | held for at least LONG_CYCLES (long-press builds only)
module quad_encoder_ctrl
  import qenc_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int CNT_MIN     = 0,
  parameter int CNT_MAX     = (1 << CNT_W) - 1,
  parameter int CNT_INIT    = 1 << (CNT_W - 1),
  parameter int WRAP        = 1,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int PB_CNT_W    = PB_CNT_W_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                A,
  input  logic                B,
  input  logic                PB,
  output logic [CNT_W-1:0]    enc_counter,
  output logic                step_cw,
  output logic                step_ccw,
  output logic                enc_err,
  output logic                pb_pressed,
  output logic                pb_short,
  output logic                pb_long,
  output logic [PB_CNT_W-1:0] pb_cnt
);

  localparam logic [CNT_W-1:0] CMIN  = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] CMAX  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CINIT = CNT_W'(CNT_INIT);

  logic a_deb;
  logic b_deb;
  logic pb_deb;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b0)) u_deb_a (
    .clk(clk), .reset(reset), .din(A), .dout(a_deb)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b0)) u_deb_b (
    .clk(clk), .reset(reset), .din(B), .dout(b_deb)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_LEVEL(1'b1)) u_deb_pb (
    .clk(clk), .reset(reset), .din(PB), .dout(pb_deb)
  );

  assign pb_pressed = ~pb_deb;

  logic [1:0]       ab_prev;
  logic [1:0]       ab_cur;
  logic signed [2:0] acc;
  logic [CNT_W-1:0] cnt_up;
  logic [CNT_W-1:0] cnt_dn;

  assign ab_cur = {a_deb, b_deb};

  always_comb begin
    cnt_up = enc_counter + CNT_W'(1);
    cnt_dn = enc_counter - CNT_W'(1);
    if (enc_counter == CMAX) cnt_up = (WRAP != 0) ? CMIN : CMAX;
    if (enc_counter == CMIN) cnt_dn = (WRAP != 0) ? CMAX : CMIN;
  end

  // A detent completes when the accumulator would reach +/-4, so it never stores +/-4.
  always_ff @(posedge clk) begin
    if (reset) begin
      ab_prev     <= 2'b00;
      acc         <= '0;
      enc_counter <= CINIT;
      step_cw     <= 1'b0;
      step_ccw    <= 1'b0;
      enc_err     <= 1'b0;
    end else begin
      ab_prev  <= ab_cur;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      enc_err  <= 1'b0;
      case (phase_delta(ab_prev, ab_cur))
        DELTA_CW: begin
          if (acc == 3'sd3) begin
            acc         <= '0;
            step_cw     <= 1'b1;
            enc_counter <= cnt_up;
          end else begin
            acc <= acc + 3'sd1;
          end
        end
        DELTA_CCW: begin
          if (acc == -3'sd3) begin
            acc         <= '0;
            step_ccw    <= 1'b1;
            enc_counter <= cnt_dn;
          end else begin
            acc <= acc - 3'sd1;
          end
        end
        DELTA_ERR: begin
          acc     <= '0;
          enc_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  btn_state_t          btn_state;
  logic [PB_CNT_W-1:0] pb_cnt_inc;

  assign pb_cnt_inc = (&pb_cnt) ? pb_cnt : pb_cnt + PB_CNT_W'(1);

`ifdef QENC_LONG_PRESS_EN
  localparam logic [PB_CNT_W-1:0] LONG_TC = PB_CNT_W'(LONG_CYCLES);
`else
  // The threshold only matters when the long-press state is built.
  logic unused_long_cycles;
  assign unused_long_cycles = (LONG_CYCLES != 0);
  assign pb_long = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_state <= IDLE;
      pb_cnt    <= '0;
      pb_short  <= 1'b0;
`ifdef QENC_LONG_PRESS_EN
      pb_long   <= 1'b0;
`endif
    end else begin
      pb_short <= 1'b0;
`ifdef QENC_LONG_PRESS_EN
      pb_long  <= 1'b0;
`endif
      case (btn_state)
        IDLE: begin
          if (pb_pressed) begin
            btn_state <= PRESSED;
            pb_cnt    <= PB_CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!pb_pressed) begin
            btn_state <= IDLE;
            pb_short  <= 1'b1;
          end else begin
            pb_cnt <= pb_cnt_inc;
`ifdef QENC_LONG_PRESS_EN
            if (pb_cnt_inc >= LONG_TC) btn_state <= LONG;
`endif
          end
        end
`ifdef QENC_LONG_PRESS_EN
        LONG: begin
          if (!pb_pressed) begin
            btn_state <= IDLE;
            pb_long   <= 1'b1;
          end else begin
            pb_cnt <= pb_cnt_inc;
          end
        end
`endif
        default: btn_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Directed bench: a wrapping and a saturating instance share the same stimulus.
module tb_quad_encoder_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic A;
  logic B;
  logic PB;

  always #5 clk = ~clk;

  logic [3:0]  cnt0, cnt1;
  logic        cw0_p, ccw0_p, err0_p, cw1_p, ccw1_p;
  logic        pressed0, short0_p, long0_p;
  logic [11:0] pbcnt0;
  logic        sat_unused_err, sat_unused_pressed, sat_unused_short, sat_unused_long;
  logic [11:0] sat_unused_pbcnt;

  quad_encoder_ctrl #(.CNT_W(4), .WRAP(1), .DEB_CYCLES(4), .PB_CNT_W(12), .LONG_CYCLES(10)) dut_wrap (
    .clk(clk), .reset(reset), .A(A), .B(B), .PB(PB),
    .enc_counter(cnt0), .step_cw(cw0_p), .step_ccw(ccw0_p), .enc_err(err0_p),
    .pb_pressed(pressed0), .pb_short(short0_p), .pb_long(long0_p), .pb_cnt(pbcnt0)
  );

  quad_encoder_ctrl #(.CNT_W(4), .WRAP(0), .DEB_CYCLES(4), .PB_CNT_W(12), .LONG_CYCLES(10)) dut_sat (
    .clk(clk), .reset(reset), .A(A), .B(B), .PB(PB),
    .enc_counter(cnt1), .step_cw(cw1_p), .step_ccw(ccw1_p), .enc_err(sat_unused_err),
    .pb_pressed(sat_unused_pressed), .pb_short(sat_unused_short), .pb_long(sat_unused_long),
    .pb_cnt(sat_unused_pbcnt)
  );

  int checks = 0;
  int failures = 0;
  int n_cw0 = 0, n_ccw0 = 0, n_err0 = 0, n_cw1 = 0, n_ccw1 = 0, n_short = 0, n_long = 0;

  always @(posedge clk) begin
    if (cw0_p)    n_cw0   <= n_cw0 + 1;
    if (ccw0_p)   n_ccw0  <= n_ccw0 + 1;
    if (err0_p)   n_err0  <= n_err0 + 1;
    if (cw1_p)    n_cw1   <= n_cw1 + 1;
    if (ccw1_p)   n_ccw1  <= n_ccw1 + 1;
    if (short0_p) n_short <= n_short + 1;
    if (long0_p)  n_long  <= n_long + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    @(negedge clk);
    {A, B} = ab;
    settle(10);
  endtask

  task automatic detent_cw();
    set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
  endtask

  task automatic detent_ccw();
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
  endtask

  typedef struct {
    logic [1:0] ab;
    int         cnt;
    int         cw;
    int         ccw;
    int         err;
  } enc_vec_t;

  enc_vec_t vecs [17];

  int s_cw, s_ccw, s_err, s_short, s_long;

  initial begin
    // {A,B}, expected counter, cumulative step_cw, step_ccw, enc_err pulses
    vecs[0]  = '{2'b10, 8, 0, 0, 0};
    vecs[1]  = '{2'b11, 8, 0, 0, 0};
    vecs[2]  = '{2'b01, 8, 0, 0, 0};
    vecs[3]  = '{2'b00, 9, 1, 0, 0};
    vecs[4]  = '{2'b01, 9, 1, 0, 0};
    vecs[5]  = '{2'b11, 9, 1, 0, 0};
    vecs[6]  = '{2'b10, 9, 1, 0, 0};
    vecs[7]  = '{2'b00, 8, 1, 1, 0};
    vecs[8]  = '{2'b11, 8, 1, 1, 1};
    vecs[9]  = '{2'b00, 8, 1, 1, 2};
    vecs[10] = '{2'b10, 8, 1, 1, 2};
    vecs[11] = '{2'b11, 8, 1, 1, 2};
    vecs[12] = '{2'b00, 8, 1, 1, 3};
    vecs[13] = '{2'b10, 8, 1, 1, 3};
    vecs[14] = '{2'b11, 8, 1, 1, 3};
    vecs[15] = '{2'b01, 8, 1, 1, 3};
    vecs[16] = '{2'b00, 9, 2, 1, 3};

    reset = 1'b1; A = 1'b0; B = 1'b0; PB = 1'b1;
    settle(3);
    check("rst enc_counter", int'(cnt0), 8);
    check("rst enc_counter sat", int'(cnt1), 8);
    check("rst pb_cnt", int'(pbcnt0), 0);
    check("rst pb_pressed", int'(pressed0), 0);
    check("rst pulses", int'({cw0_p, ccw0_p, err0_p, short0_p, long0_p}), 0);
    reset = 1'b0;
    settle(2);

    for (int i = 0; i < 17; i++) begin
      set_ab(vecs[i].ab);
      check($sformatf("vec%0d cnt_wrap", i), int'(cnt0), vecs[i].cnt);
      check($sformatf("vec%0d cnt_sat", i), int'(cnt1), vecs[i].cnt);
      check($sformatf("vec%0d step_cw", i), n_cw0, vecs[i].cw);
      check($sformatf("vec%0d step_ccw", i), n_ccw0, vecs[i].ccw);
      check($sformatf("vec%0d enc_err", i), n_err0, vecs[i].err);
    end

    // Glitches of DEB_CYCLES-1 cycles must be invisible.
    @(negedge clk); A = 1'b1; settle(3); A = 1'b0; settle(12);
    @(negedge clk); {A, B} = 2'b11; settle(3); {A, B} = 2'b00; settle(12);
    check("glitch cnt", int'(cnt0), 9);
    check("glitch step_cw", n_cw0, 2);
    check("glitch step_ccw", n_ccw0, 1);
    check("glitch enc_err", n_err0, 3);

    for (int i = 0; i < 6; i++) detent_cw();
    check("to max wrap", int'(cnt0), 15);
    check("to max sat", int'(cnt1), 15);
    detent_cw();
    check("wrap 15->0", int'(cnt0), 0);
    check("sat holds 15", int'(cnt1), 15);
    check("sat step_cw pulses", n_cw1, 9);
    check("wrap step_cw pulses", n_cw0, 9);
    detent_ccw();
    check("wrap 0->15", int'(cnt0), 15);
    check("sat 15->14", int'(cnt1), 14);
    check("sat step_ccw pulses", n_ccw1, 2);

    // 5-cycle press
    @(negedge clk); PB = 1'b0; settle(5); PB = 1'b1; settle(12);
    check("short pb_short", n_short, 1);
    check("short pb_long", n_long, 0);
    check("short pb_cnt", int'(pbcnt0), 5);
    check("short pb_pressed", int'(pressed0), 0);
    settle(5);
    check("idle pb_cnt hold", int'(pbcnt0), 5);

    // 20-cycle press
    @(negedge clk); PB = 1'b0; settle(10);
    check("long mid pb_pressed", int'(pressed0), 1);
    check("long mid pb_cnt", int'(pbcnt0), 4);
    settle(10); PB = 1'b1; settle(12);
    check("long pb_cnt", int'(pbcnt0), 20);
`ifdef QENC_LONG_PRESS_EN
    check("long pb_long", n_long, 1);
    check("long pb_short", n_short, 1);
`else
    check("long pb_long", n_long, 0);
    check("long pb_short", n_short, 2);
`endif

    // Reset during a press and a partial encoder step
    s_short = n_short; s_long = n_long;
    @(negedge clk); PB = 1'b0; A = 1'b1; settle(15);
    check("pre-rst pb_cnt", int'(pbcnt0), 9);
    reset = 1'b1; settle(2);
    check("mid-rst pb_cnt", int'(pbcnt0), 0);
    check("mid-rst pb_pressed", int'(pressed0), 0);
    check("mid-rst cnt_wrap", int'(cnt0), 8);
    check("mid-rst cnt_sat", int'(cnt1), 8);
    PB = 1'b1; A = 1'b0; settle(6);
    reset = 1'b0;
    s_cw = n_cw0; s_ccw = n_ccw0; s_err = n_err0;
    settle(20);
    check("post-rst pb_short", n_short - s_short, 0);
    check("post-rst pb_long", n_long - s_long, 0);
    check("post-rst pb_cnt", int'(pbcnt0), 0);
    check("post-rst cnt", int'(cnt0), 8);
    check("post-rst enc pulses", (n_cw0 - s_cw) + (n_ccw0 - s_ccw) + (n_err0 - s_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_encoder_ctrl.md
QUAD_ENCODER_CTRL -- requirements
Module: quad_encoder_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of enc_counter.
REQ-002 Parameter CNT_MIN, default 0; CNT_MAX, default 2**CNT_W-1; CNT_INIT, default 2**(CNT_W-1): counter range and reset value.
REQ-003 Parameter WRAP, default 1: 1 = wrap at range ends, 0 = saturate.
REQ-004 Parameter DEB_CYCLES, default 16: required input stability, in cycles, before a debounced level changes.
REQ-005 Parameter PB_CNT_W, default 12; LONG_CYCLES, default 2000: press-duration counter width and long-press threshold.
REQ-006 clk  in  1  single clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 A, B  in  1 each  raw asynchronous quadrature phases.
REQ-009 PB  in  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-010 enc_counter  out  CNT_W  position counter.
REQ-011 step_cw, step_ccw  out  1 each  one-cycle pulse per detent step.
REQ-012 enc_err  out  1  one-cycle pulse on an illegal phase transition.
REQ-013 pb_pressed  out  1  debounced press level.
REQ-014 pb_short, pb_long  out  1 each  one-cycle pulse on release, classified by press length.
REQ-015 pb_cnt  out  PB_CNT_W  cycles the current press has lasted; holds the final value after release.

Function
REQ-016 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEB_CYCLES consecutive equal synchronized samples. Total latency is 2+DEB_CYCLES cycles.
REQ-017 The decoder SHALL compare the debounced {A,B} with the previous value each cycle. Gray sequence 00->10->11->01->00 is +1 (CW); the reverse sequence is -1 (CCW); no change is 0.
REQ-018 A change of both phases in one cycle SHALL pulse enc_err, clear the sub-step accumulator and leave enc_counter unchanged.
REQ-019 The signed 3-bit sub-step accumulator reaching +4 SHALL pulse step_cw, add 1 to enc_counter and clear the accumulator; reaching -4 SHALL pulse step_ccw, subtract 1 and clear it. Both actions occur in the same cycle.
REQ-020 With WRAP=1, an increment at CNT_MAX SHALL give CNT_MIN and a decrement at CNT_MIN SHALL give CNT_MAX. With WRAP=0, the counter holds at the limit and the step pulse is still emitted.
REQ-021 The button FSM SHALL have states IDLE, PRESSED, LONG.
- IDLE->PRESSED on debounced press; pb_cnt loads 1.
- PRESSED: pb_cnt increments each cycle and saturates at all-ones.
- PRESSED->LONG when pb_cnt reaches LONG_CYCLES.
- Release from PRESSED pulses pb_short; release from LONG pulses pb_long; both releases return to IDLE.
REQ-022 pb_cnt SHALL hold its value in IDLE until the next press.
REQ-023 Encoder and button paths SHALL be independent; simultaneous events produce all their pulses in the same cycle.

Reset
REQ-024 While reset=1, all state SHALL take its reset value on every clock edge:
- enc_counter=CNT_INIT, accumulator=0, all pulses=0, pb_cnt=0, FSM=IDLE, pb_pressed=0;
- synchronizers and debouncers preset to idle level A=0, B=0, PB=1.
REQ-025 Reset asserted mid-press or mid-step SHALL discard the event; no pulse is emitted on or after deassertion for that event.

Configuration
REQ-026 Macro QENC_LONG_PRESS_EN: when defined, the LONG state and pb_long behave per REQ-021.
REQ-027 Without QENC_LONG_PRESS_EN, the LONG state is not built, pb_long is tied to 0, and every release pulses pb_short.

Structure
REQ-028 Package qenc_pkg SHALL hold the button-state enum (IDLE, PRESSED, LONG), the phase-delta encoding, and the parameter default constants.
REQ-029 Sub-module input_debounce (synchronizer plus debouncer, parameter DEB_CYCLES, reset level input) SHALL be instantiated three times.

Verification
REQ-030 With CNT_W=4, DEB_CYCLES=4, four clean CW Gray steps -> exactly one step_cw and enc_counter 8->9; four CCW steps -> step_ccw and 9->8.
REQ-031 A glitch shorter than DEB_CYCLES on A -> no enc_counter, step or err change.
REQ-032 WRAP=1, counter at 15, one CW detent -> 0. WRAP=0, counter at 15 -> stays 15 and step_cw still pulses.
REQ-033 {A,B} changes 00->11 in one cycle -> enc_err pulse for one cycle, accumulator cleared.
REQ-034 LONG_CYCLES=10: a 5-cycle press -> pb_short and pb_cnt=5; a 20-cycle press -> pb_long (pb_short without the macro).
REQ-035 reset asserted during a press -> pb_cnt=0, FSM=IDLE, enc_counter=CNT_INIT, and no release pulse after deassertion.
